matrix_column_scanner: RTL and testbench

Downstream consumer of the irrigation-mode image decoder. It takes the three mirrored column images (col_2, col_1, col_0) and time-multiplexes them onto the CPLD kit's 7x5 LED matrix. Each frame it drives one physical column at a time with its row pattern, and it adds inter-column blanking, frame-coherent sampling and optional blinking.

---
 rtl/matrix_pkg.sv | 39 +++
 rtl/scan_prescaler.sv | 28 ++
 rtl/matrix_column_scanner.sv | 140 ++++++++++++++
 tb/tb_matrix_column_scanner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types, sizes and helpers for the LED matrix column scanner.
package matrix_pkg;

  localparam int unsigned NUM_ROWS    = 7;
  localparam int unsigned NUM_COLUMNS = 5;
  localparam int unsigned IDX_W       = 3;

  typedef logic [IDX_W-1:0]       col_idx_t;
  typedef logic [NUM_ROWS-1:0]    row_t;
  typedef logic [NUM_COLUMNS-1:0] col_sel_t;

  typedef enum logic [1:0] {
    SLOT_C0 = 2'd0,
    SLOT_C1 = 2'd1,
    SLOT_C2 = 2'd2
  } img_slot_t;

  localparam col_idx_t LAST_COLUMN = col_idx_t'(NUM_COLUMNS - 1);

  // The three column images are mirrored around the centre column.
  function automatic img_slot_t column_slot(input col_idx_t idx);
    img_slot_t slot;
    case (idx)
      3'd0, 3'd4: slot = SLOT_C2;
      3'd1, 3'd3: slot = SLOT_C1;
      default:    slot = SLOT_C0;
    endcase
    return slot;
  endfunction

  function automatic row_t row_inactive(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

  function automatic col_sel_t col_inactive(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-MODULUS counter with count enable, synchronous clear and wrap tick.
module scan_prescaler #(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned WIDTH   = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tick_c
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign tick_c = enable && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick_c) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/matrix_column_scanner.sv
// Time-multiplexes three mirrored column images onto a 7x5 LED matrix with
// inter-column blanking, per-frame image sampling and optional blinking.
module matrix_column_scanner
  import matrix_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 1000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned BLINK_FRAMES   = 50,
  parameter bit          ROW_ACTIVE_LOW = 1'b1,
  parameter bit          COL_ACTIVE_LOW = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   blink_enable,
  input  logic [NUM_ROWS-1:0]    col_2,
  input  logic [NUM_ROWS-1:0]    col_1,
  input  logic [NUM_ROWS-1:0]    col_0,
  output logic [NUM_ROWS-1:0]    row,
  output logic [NUM_COLUMNS-1:0] column_select,
  output logic                   frame_start
);

  localparam int unsigned PRE_W  = $clog2(DWELL_CYCLES);
  localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam row_t     ROW_OFF = row_inactive(ROW_ACTIVE_LOW);
  localparam col_sel_t COL_OFF = col_inactive(COL_ACTIVE_LOW);

  logic [PRE_W-1:0]  pre;
  logic              pre_tick_c;
  logic [FCNT_W-1:0] fcnt;
  logic              fcnt_tick_c;
  logic              unused_fcnt_bits;
  col_idx_t          idx;
  logic              phase;
  row_t              s2, s1, s0;

  logic     load_c;
  logic     frame_done_c;
  logic     blink_run_c;
  logic     visible_c;
  row_t     img_c;
  row_t     row_nxt_c;
  col_sel_t col_nxt_c;

  assign load_c       = enable && (pre == '0) && (idx == '0);
  assign frame_done_c = pre_tick_c && (idx == LAST_COLUMN);
  assign blink_run_c  = enable && blink_enable;

  // Frame counter value is only consumed through its wrap tick.
  assign unused_fcnt_bits = ^fcnt;

  scan_prescaler #(
    .MODULUS (DWELL_CYCLES),
    .WIDTH   (PRE_W)
  ) u_dwell (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (!enable),
    .count  (pre),
    .tick_c (pre_tick_c)
  );

  // Counts completed frames so the frame that starts a blink run stays lit.
  scan_prescaler #(
    .MODULUS (BLINK_FRAMES),
    .WIDTH   (FCNT_W)
  ) u_frames (
    .clock  (clock),
    .reset  (reset),
    .enable (frame_done_c),
    .clear  (!blink_run_c),
    .count  (fcnt),
    .tick_c (fcnt_tick_c)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (!enable) begin
      idx <= '0;
    end else if (pre_tick_c) begin
      idx <= (idx == LAST_COLUMN) ? '0 : idx + col_idx_t'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
    end else if (!blink_run_c) begin
      phase <= 1'b0;
    end else if (fcnt_tick_c) begin
      phase <= ~phase;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2 <= '0;
      s1 <= '0;
      s0 <= '0;
    end else if (load_c) begin
      s2 <= col_2;
      s1 <= col_1;
      s0 <= col_0;
    end
  end

  // The load cycle reads the inputs directly so BLANK_CYCLES=0 shows the new frame.
  always_comb begin
    img_c     = '0;
    row_nxt_c = ROW_OFF;
    col_nxt_c = COL_OFF;
    case (column_slot(idx))
      SLOT_C2: img_c = load_c ? col_2 : s2;
      SLOT_C1: img_c = load_c ? col_1 : s1;
      default: img_c = load_c ? col_0 : s0;
    endcase
    visible_c = enable && (pre >= PRE_W'(BLANK_CYCLES)) && !(blink_enable && phase);
    if (visible_c) begin
      row_nxt_c = img_c ^ ROW_OFF;
      col_nxt_c = (col_sel_t'(1) << idx) ^ COL_OFF;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row           <= ROW_OFF;
      column_select <= COL_OFF;
      frame_start   <= 1'b0;
    end else begin
      row           <= row_nxt_c;
      column_select <= col_nxt_c;
      frame_start   <= load_c;
    end
  end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// Directed and randomized bench for matrix_column_scanner against a cycle-position model.
module tb_matrix_column_scanner;

  localparam int unsigned DWELL = 4;
  localparam int unsigned BLANK = 1;
  localparam int unsigned BLINK = 2;
  localparam int unsigned FRAME = 5 * DWELL;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       blink_enable;
  logic [6:0] col_2, col_1, col_0;
  logic [6:0] row;
  logic [4:0] column_select;
  logic       frame_start;

  always #5 clock = ~clock;

  matrix_column_scanner #(
    .DWELL_CYCLES   (DWELL),
    .BLANK_CYCLES   (BLANK),
    .BLINK_FRAMES   (BLINK),
    .ROW_ACTIVE_LOW (1'b1),
    .COL_ACTIVE_LOW (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .blink_enable  (blink_enable),
    .col_2         (col_2),
    .col_1         (col_1),
    .col_0         (col_0),
    .row           (row),
    .column_select (column_select),
    .frame_start   (frame_start)
  );

  int checks = 0;
  int errors = 0;
  int fs_seen = 0;

  // Model: position within the scan, sampled frame images, completed blink frames.
  int         pos;
  int         bframes;
  logic [6:0] sh [3];
  logic [6:0] exp_row;
  logic [4:0] exp_cs;
  logic       exp_fs;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pos     = 0;
    bframes = 0;
    for (int i = 0; i < 3; i++) sh[i] = 7'h00;
  endtask

  task automatic step();
    logic [6:0] img [5];
    logic       load, dark, vis;
    int         col, off;
    load = enable && (pos % FRAME == 0);
    col  = (pos / DWELL) % 5;
    off  = pos % DWELL;
    if (load) img = '{col_2, col_1, col_0, col_1, col_2};
    else      img = '{sh[2], sh[1], sh[0], sh[1], sh[2]};
    dark = blink_enable && ((bframes / BLINK) % 2 == 1);
    vis  = enable && (off >= BLANK) && !dark;
    exp_row = vis ? ~img[col] : 7'h7F;
    exp_cs  = vis ? ~(5'b00001 << col) : 5'h1F;
    exp_fs  = load;
    if (load) begin
      sh[2] = col_2;
      sh[1] = col_1;
      sh[0] = col_0;
    end
    if (!enable || !blink_enable) bframes = 0;
    else if (pos % FRAME == FRAME - 1) bframes++;
    pos = enable ? pos + 1 : 0;
    @(posedge clock);
    #1;
    chk("row", 8'(row), 8'(exp_row));
    chk("column_select", 8'(column_select), 8'(exp_cs));
    chk("frame_start", 8'(frame_start), 8'(exp_fs));
    chk("one_hot", 8'($countones(~column_select) <= 1), 8'd1);
    chk("rows_off_when_no_column", 8'((column_select == 5'h1F) ? row : 7'h7F), 8'h7F);
    if (frame_start) fs_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (pos % FRAME != target) begin
      step();
      guard++;
      if (guard > 4 * FRAME) begin
        chk("run_until_timeout", 8'd0, 8'd1);
        break;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    blink_enable = 1'b0;
    col_2        = 7'h55;
    col_1        = 7'h2A;
    col_0        = 7'h7F;
    model_reset();
    #3;
    chk("reset_row", 8'(row), 8'h7F);
    chk("reset_cs", 8'(column_select), 8'h1F);
    chk("reset_fs", 8'(frame_start), 8'h00);
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b1;

    // Basic scan: two frames, one frame_start per 20 cycles.
    fs_seen = 0;
    run(2 * FRAME);
    chk("frame_count", 8'(fs_seen), 8'd2);
    run_until(2);
    chk("col0_row", 8'(row), 8'h2A);
    chk("col0_cs", 8'(column_select), 8'h1E);
    run_until(6);
    chk("col1_row", 8'(row), 8'h55);
    chk("col1_cs", 8'(column_select), 8'h1D);
    run_until(10);
    chk("col2_row", 8'(row), 8'h00);
    chk("col2_cs", 8'(column_select), 8'h1B);

    // Frame coherence: new col_2 mid-frame appears only next frame.
    col_2 = 7'h01;
    run_until(18);
    chk("coherent_col4_row", 8'(row), 8'h2A);
    chk("coherent_col4_cs", 8'(column_select), 8'h0F);
    run_until(2);
    chk("new_frame_col0_row", 8'(row), 8'h7E);

    // Blink: frames 0-1 lit, 2-3 dark; release mid-dark restores next cycle.
    run_until(0);
    blink_enable = 1'b1;
    run(2 * FRAME + 10);
    chk("blink_dark_cs", 8'(column_select), 8'h1F);
    blink_enable = 1'b0;
    step();
    chk("blink_restore_cs", 8'(column_select), 8'h1B);
    blink_enable = 1'b1;
    run(6 * FRAME);
    blink_enable = 1'b0;

    // Enable toggle at column 3.
    run_until(14);
    chk("pre_disable_cs", 8'(column_select), 8'h17);
    enable = 1'b0;
    step();
    chk("disable_cs", 8'(column_select), 8'h1F);
    chk("disable_row", 8'(row), 8'h7F);
    run(3);
    enable = 1'b1;
    step();
    chk("reenable_fs", 8'(frame_start), 8'h01);
    step();
    chk("restart_col0_cs", 8'(column_select), 8'h1E);

    // Asynchronous reset between edges.
    run_until(4);
    chk("pre_reset_cs", 8'(column_select), 8'h1E);
    #2;
    reset = 1'b1;
    #1;
    chk("async_row", 8'(row), 8'h7F);
    chk("async_cs", 8'(column_select), 8'h1F);
    chk("async_fs", 8'(frame_start), 8'h00);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step();
    chk("post_reset_fs", 8'(frame_start), 8'h01);
    run_until(2);
    chk("post_reset_col0_cs", 8'(column_select), 8'h1E);

    // Random inputs over ten frames.
    for (int i = 0; i < 10 * FRAME; i++) begin
      col_2  = 7'($urandom);
      col_1  = 7'($urandom);
      col_0  = 7'($urandom);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) blink_enable = ~blink_enable;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
